// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencing controller for the 5-stage core. Resolves the hazards
//   that forwarding cannot: load-use stalls, taken-branch flushes and
//   multi-cycle MDU execution (start/done handshake with timeout abort).
//   Also keeps saturating stall/flush counters for performance monitoring.
//
// Ports
//   clk, reset_n                  clock (rising edge), async active-low reset
//   rs1_id, rs2_id                source registers of the instruction in ID
//   rs1_used, rs2_used            ID instruction really reads rs1/rs2
//   rd_ex, mem_read_ex            destination / is-load of the instruction in EX
//   branch_taken_ex               EX resolved a taken branch/jump
//   mdu_op_ex, mdu_done           MDU op in EX / MDU result valid
//   pc_en .. ex_mem_en            stage register enables
//   if_id_flush .. ex_mem_flush   load a bubble into that register
//   mdu_start                     one-cycle MDU launch pulse
//   mdu_timeout                   sticky MDU abort flag
//   busy                          waiting on the MDU
//   stall_cnt, flush_cnt          saturating performance counters
module hazard_controller #(
   parameter int unsigned REG_ADDR_W  = 6,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MDU_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [REG_ADDR_W-1:0] rs1_id,
   input  logic [REG_ADDR_W-1:0] rs2_id,
   input  logic                  rs1_used,
   input  logic                  rs2_used,
   input  logic [REG_ADDR_W-1:0] rd_ex,
   input  logic                  mem_read_ex,
   input  logic                  branch_taken_ex,
   input  logic                  mdu_op_ex,
   input  logic                  mdu_done,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  id_ex_en,
   output logic                  ex_mem_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic                  mdu_start,
   output logic                  mdu_timeout,
   output logic                  busy,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int unsigned WCNT_W = $clog2(MDU_TIMEOUT + 1);

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
   logic               mdu_timeout_q, mdu_timeout_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
   logic               load_use;

   // x0 is hard-wired zero, so a load targeting it never creates a hazard.
   always_comb begin
      load_use = mem_read_ex && (rd_ex != '0) &&
                 ((rs1_used && (rs1_id == rd_ex)) ||
                  (rs2_used && (rs2_id == rd_ex)));
   end

   always_comb begin
      state_d       = state_q;
      wcnt_d        = wcnt_q;
      mdu_timeout_d = mdu_timeout_q;
      pc_en         = 1'b1;
      if_id_en      = 1'b1;
      id_ex_en      = 1'b1;
      ex_mem_en     = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      mdu_start     = 1'b0;
      busy          = 1'b0;

      case (state_q)
         RUN: begin
            if (branch_taken_ex) begin
               // Redirect wins: the MDU op in EX is on the wrong path.
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (mdu_op_ex) begin
               mdu_start    = 1'b1;
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_en     = 1'b0;
               ex_mem_flush = 1'b1;
               state_d      = MDU_WAIT;
               wcnt_d       = WCNT_W'(1);
            end else if (load_use) begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
            end
         end

         MDU_WAIT: begin
            busy = 1'b1;
            if (mdu_done) begin
               state_d = RUN;
               wcnt_d  = '0;
            end else if (wcnt_q == WCNT_W'(MDU_TIMEOUT)) begin
               // Abort: release the pipeline but push a bubble instead of a result.
               mdu_timeout_d = 1'b1;
               ex_mem_flush  = 1'b1;
               state_d       = RUN;
               wcnt_d        = '0;
            end else begin
               pc_en        = 1'b0;
               if_id_en     = 1'b0;
               id_ex_en     = 1'b0;
               ex_mem_flush = 1'b1;
               wcnt_d       = wcnt_q + WCNT_W'(1);
            end
         end

         default: begin
            state_d = RUN;
            wcnt_d  = '0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (if_id_flush && (flush_cnt_q != '1)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RUN;
         wcnt_q        <= '0;
         mdu_timeout_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         wcnt_q        <= wcnt_d;
         mdu_timeout_q <= mdu_timeout_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   always_comb begin
      mdu_timeout = mdu_timeout_q;
      stall_cnt   = stall_cnt_q;
      flush_cnt   = flush_cnt_q;
   end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed bench for hazard_controller: a table of single-cycle RUN-state
//   vectors plus hand-written multi-cycle sequences (MDU handshake, timeout,
//   reset during MDU wait, counter saturation). MDU_TIMEOUT is set to 4.
module tb_hazard_controller;

   localparam int unsigned AW = 6;
   localparam int unsigned CW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
   logic          rs1_used = 1'b0, rs2_used = 1'b0, mem_read_ex = 1'b0;
   logic          branch_taken_ex = 1'b0, mdu_op_ex = 1'b0, mdu_done = 1'b0;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic          if_id_flush, id_ex_flush, ex_mem_flush;
   logic          mdu_start, mdu_timeout, busy;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   hazard_controller #(
      .REG_ADDR_W (AW),
      .CNT_W      (CW),
      .MDU_TIMEOUT(4)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .rs1_id         (rs1_id),
      .rs2_id         (rs2_id),
      .rs1_used       (rs1_used),
      .rs2_used       (rs2_used),
      .rd_ex          (rd_ex),
      .mem_read_ex    (mem_read_ex),
      .branch_taken_ex(branch_taken_ex),
      .mdu_op_ex      (mdu_op_ex),
      .mdu_done       (mdu_done),
      .pc_en          (pc_en),
      .if_id_en       (if_id_en),
      .id_ex_en       (id_ex_en),
      .ex_mem_en      (ex_mem_en),
      .if_id_flush    (if_id_flush),
      .id_ex_flush    (id_ex_flush),
      .ex_mem_flush   (ex_mem_flush),
      .mdu_start      (mdu_start),
      .mdu_timeout    (mdu_timeout),
      .busy           (busy),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   always #5 clk = ~clk;

   // Output bundle order: {pc_en, if_id_en, id_ex_en, ex_mem_en,
   //                       if_id_flush, id_ex_flush, ex_mem_flush, mdu_start, busy}
   localparam logic [8:0] O_NORM  = 9'b1111_000_0_0;
   localparam logic [8:0] O_LU    = 9'b0011_010_0_0;
   localparam logic [8:0] O_BR    = 9'b1111_110_0_0;
   localparam logic [8:0] O_START = 9'b0001_001_1_0;
   localparam logic [8:0] O_WAIT  = 9'b0001_001_0_1;
   localparam logic [8:0] O_DONE  = 9'b1111_000_0_1;
   localparam logic [8:0] O_ABORT = 9'b1111_001_0_1;

   typedef struct {
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic          u1;
      logic          u2;
      logic [AW-1:0] rd;
      logic          ld;
      logic          br;
      logic          mop;
      logic          done;
      logic [8:0]    exp;
   } vec_t;

   vec_t tbl[13];

   function automatic logic [8:0] outs();
      return {pc_en, if_id_en, id_ex_en, ex_mem_en,
              if_id_flush, id_ex_flush, ex_mem_flush, mdu_start, busy};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string nm, input logic [8:0] exp);
      chk(nm, 32'(outs()), 32'(exp));
   endtask

   task automatic drive(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic [AW-1:0] rd,
                        input logic ld, input logic br, input logic mop,
                        input logic done);
      rs1_id = rs1; rs2_id = rs2; rs1_used = u1; rs2_used = u2; rd_ex = rd;
      mem_read_ex = ld; branch_taken_ex = br; mdu_op_ex = mop; mdu_done = done;
   endtask

   // Inputs already driven; sample combinational outputs mid-cycle, then
   // advance past the next rising edge.
   task automatic step(input string nm, input logic [8:0] exp);
      @(negedge clk);
      chk_outs(nm, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{6'd0,  6'd0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[1]  = '{6'd5,  6'd0, 1'b1, 1'b0, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_LU};
      tbl[2]  = '{6'd0,  6'd0, 1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[3]  = '{6'd5,  6'd0, 1'b0, 1'b0, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[4]  = '{6'd1,  6'd5, 1'b1, 1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_LU};
      tbl[5]  = '{6'd5,  6'd5, 1'b0, 1'b0, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[6]  = '{6'd5,  6'd0, 1'b1, 1'b0, 6'd5,  1'b0, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[7]  = '{6'h3F, 6'd0, 1'b1, 1'b0, 6'h3F, 1'b1, 1'b0, 1'b0, 1'b0, O_LU};
      tbl[8]  = '{6'd4,  6'd6, 1'b1, 1'b1, 6'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_NORM};
      tbl[9]  = '{6'd0,  6'd0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b1, 1'b0, 1'b0, O_BR};
      tbl[10] = '{6'd5,  6'd0, 1'b1, 1'b0, 6'd5,  1'b1, 1'b1, 1'b1, 1'b0, O_BR};
      tbl[11] = '{6'd0,  6'd0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 1'b0, 1'b1, O_NORM};
      tbl[12] = '{6'd0,  6'd7, 1'b0, 1'b1, 6'd7,  1'b1, 1'b1, 1'b0, 1'b0, O_BR};

      // Reset state
      idle();
      reset_n = 1'b0;
      #3;
      chk_outs("reset_outs", O_NORM);
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("reset_timeout", 32'(mdu_timeout), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Single load-use cycle, then counter visible next cycle
      drive(6'd5, 6'd0, 1'b1, 1'b0, 6'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      step("lu_single", O_LU);
      idle();
      chk("lu_single_stall_cnt", 32'(stall_cnt), 32'd1);
      step("lu_released", O_NORM);

      // Table vectors in RUN: 3 load-use stalls, 3 branch flushes
      do_reset();
      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].rs1, tbl[i].rs2, tbl[i].u1, tbl[i].u2, tbl[i].rd,
               tbl[i].ld, tbl[i].br, tbl[i].mop, tbl[i].done);
         step($sformatf("vec%0d", i), tbl[i].exp);
      end
      idle();
      chk("tbl_stall_cnt", 32'(stall_cnt), 32'd3);
      chk("tbl_flush_cnt", 32'(flush_cnt), 32'd3);

      // MDU with done at T+4; hazards/branch during wait are ignored
      do_reset();
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("mdu4_T0_start", O_START);
      drive(6'd5, '0, 1'b1, 1'b0, 6'd5, 1'b1, 1'b0, 1'b1, 1'b0);
      step("mdu4_T1_wait_lu_masked", O_WAIT);
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      step("mdu4_T2_wait_br_ignored", O_WAIT);
      idle();
      step("mdu4_T3_wait", O_WAIT);
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("mdu4_T4_done", O_DONE);
      idle();
      step("mdu4_T5_run", O_NORM);
      chk("mdu4_stall_cnt", 32'(stall_cnt), 32'd4);
      chk("mdu4_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("mdu4_no_timeout", 32'(mdu_timeout), 32'd0);

      // Earliest done at T+1
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("mdu1_T0_start", O_START);
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("mdu1_T1_done", O_DONE);
      idle();
      step("mdu1_T2_run", O_NORM);
      chk("mdu1_stall_cnt", 32'(stall_cnt), 32'd5);

      // Timeout: MDU_TIMEOUT=4, done never comes -> abort at T+4
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("to_T0_start", O_START);
      idle();
      step("to_T1_wait", O_WAIT);
      step("to_T2_wait", O_WAIT);
      step("to_T3_wait", O_WAIT);
      @(negedge clk);
      chk("to_T4_flag_not_yet", 32'(mdu_timeout), 32'd0);
      chk_outs("to_T4_abort", O_ABORT);
      @(posedge clk);
      #1;
      chk("to_T5_flag", 32'(mdu_timeout), 32'd1);
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      step("to_T5_run_late_done", O_NORM);
      idle();
      step("to_T6_run", O_NORM);
      step("to_T7_run", O_NORM);
      chk("to_flag_sticky", 32'(mdu_timeout), 32'd1);
      chk("to_stall_cnt", 32'(stall_cnt), 32'd9);

      // Reset asserted mid-MDU_WAIT
      drive('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
      step("rst_T0_start", O_START);
      idle();
      step("rst_T1_wait", O_WAIT);
      #2;
      reset_n = 1'b0;
      #1;
      chk_outs("rst_async_outs", O_NORM);
      chk("rst_async_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_async_flush_cnt", 32'(flush_cnt), 32'd0);
      chk("rst_async_timeout", 32'(mdu_timeout), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      step("rst_after_no_restart", O_NORM);
      step("rst_after_run", O_NORM);

      // Stall counter saturation over 2^16+3 cycles
      do_reset();
      drive(6'd9, '0, 1'b1, 1'b0, 6'd9, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (65534) @(posedge clk);
      #1;
      chk("sat_fffe", 32'(stall_cnt), 32'h0000_FFFE);
      @(posedge clk);
      #1;
      chk("sat_ffff", 32'(stall_cnt), 32'h0000_FFFF);
      repeat (4) @(posedge clk);
      #1;
      chk("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);
      chk_outs("sat_still_stalling", O_LU);
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
